// File: rtl/uart_rx_if.sv
// Consumer-side handshake of the UART receiver: received byte, valid/ack
// handshake and the two one-cycle error pulses.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       rx_frame_err;
  logic       rx_overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_frame_err,
    output rx_overrun,
    input  rx_ack
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  rx_frame_err,
    input  rx_overrun,
    output rx_ack
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronized line, mid-bit sampling from the start
// edge, one-byte holding register with valid/ack handshake and error pulses.
module uart_rx #(
  parameter int BAUD_RATE   = 115200,
  parameter int CLK_VAL_MHZ = 50
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  uart_rx_if.master bus
);

  // BAUD_DIV must lie in 2..8191 to fit the 13-bit counter.
  localparam int BAUD_DIV = CLK_VAL_MHZ * 1000000 / BAUD_RATE;
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int CNT_W    = 13;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       sync;
  logic             rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  logic half_tick, baud_tick;
  logic sample_en, byte_done, frame_err_set, cnt_clr;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // sees pre-edge values and process ordering cannot change behaviour.
  always_ff @(posedge clk) begin
    if (!rst) sync <= 2'b11;
    else      sync <= {sync[0], rx};
  end

  assign rx_s      = sync[1];
  assign half_tick = (cnt == CNT_W'(HALF_DIV - 1));
  assign baud_tick = (cnt == CNT_W'(BAUD_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (!rx_s) state_nxt = S_START;
      S_START:     if (half_tick) state_nxt = rx_s ? S_IDLE : S_DATA;
      S_DATA:      if (baud_tick && bit_idx == 3'd7) state_nxt = S_STOP;
      S_STOP:      if (baud_tick) state_nxt = rx_s ? S_IDLE : S_WAIT_IDLE;
      S_WAIT_IDLE: if (rx_s) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    sample_en     = (state == S_DATA) && baud_tick;
    byte_done     = (state == S_STOP) && baud_tick && rx_s;
    frame_err_set = (state == S_STOP) && baud_tick && !rx_s;
    // The counter restarts on every state entry and after each data sample;
    // it only runs while a frame is being timed.
    cnt_clr       = (state_nxt != state) || sample_en ||
                    !(state == S_START || state == S_DATA || state == S_STOP);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + CNT_W'(1);
      if (sample_en) begin
        shift   <= {rx_s, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.rx_data      <= 8'h00;
      bus.rx_valid     <= 1'b0;
      bus.rx_frame_err <= 1'b0;
      bus.rx_overrun   <= 1'b0;
    end else begin
      bus.rx_frame_err <= frame_err_set;
      bus.rx_overrun   <= byte_done && bus.rx_valid && !bus.rx_ack;
      if (byte_done && (!bus.rx_valid || bus.rx_ack)) begin
        bus.rx_data  <= shift;
        bus.rx_valid <= 1'b1;
      end else if (bus.rx_valid && bus.rx_ack) begin
        bus.rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 50 MHz / 115200 baud: clean frames, framing
// error recovery, glitch rejection, overrun, ack-at-completion, mid-frame reset.
module tb_uart_rx;

  localparam int BIT  = 434;
  localparam int HALF = 217;
  // Cycles from the start-bit drive edge to the first rx_valid observation:
  // 2 sync stages, half-bit start check, 9 full bits, 1 output register.
  localparam int LATENCY = 2 + HALF + 9 * BIT + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx  = 1'b1;

  uart_rx_if bus ();

  uart_rx #(
    .BAUD_RATE  (115200),
    .CLK_VAL_MHZ(50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx (rx),
    .bus(bus)
  );

  always #10 clk = ~clk;

  int   cyc       = 0;
  int   n_err     = 0;
  int   n_ovr     = 0;
  int   n_rise    = 0;
  int   rise_cyc  = 0;
  int   start_cyc = 0;
  int   n_checks  = 0;
  int   n_fail    = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rx_frame_err) n_err = n_err + 1;
    if (bus.rx_overrun)   n_ovr = n_ovr + 1;
    if (bus.rx_valid && !prev_valid) begin
      n_rise   = n_rise + 1;
      rise_cyc = cyc;
    end
    prev_valid = bus.rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One bit period on the line; ack_at >= 0 raises rx_ack for exactly the
  // cycle at that offset into the bit.
  task automatic drive_bit(input logic v, input int ack_at);
    rx = v;
    for (int i = 0; i < BIT; i++) begin
      if (ack_at >= 0) bus.rx_ack = (i == ack_at);
      @(negedge clk);
    end
    if (ack_at >= 0) bus.rx_ack = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] data, input logic stop, input logic ack_done);
    start_cyc = cyc;
    drive_bit(1'b0, -1);
    for (int k = 0; k < 8; k++) drive_bit(data[k], -1);
    drive_bit(stop, ack_done ? (2 + HALF) : -1);
    rx = 1'b1;
  endtask

  task automatic ack_pulse();
    bus.rx_ack = 1'b1;
    @(negedge clk);
    bus.rx_ack = 1'b0;
  endtask

  int r0, e0, o0;
  logic [7:0] pat;

  initial begin
    bus.rx_ack = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_data", bus.rx_data, 8'h00);
    check("rst_valid", bus.rx_valid, 1'b0);
    check("rst_ferr", bus.rx_frame_err, 1'b0);
    check("rst_ovr", bus.rx_overrun, 1'b0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_valid", bus.rx_valid, 1'b0);

    // 0x55, exact latency, then ack and ignored ack
    r0 = n_rise;
    send_byte(8'h55, 1'b1, 1'b0);
    check("b55_rises", n_rise - r0, 1);
    check("b55_latency", rise_cyc - start_cyc, LATENCY);
    check("b55_valid", bus.rx_valid, 1'b1);
    check("b55_data", bus.rx_data, 8'h55);
    ack_pulse();
    check("ack_valid_low", bus.rx_valid, 1'b0);
    check("ack_data_kept", bus.rx_data, 8'h55);
    bus.rx_ack = 1'b1;
    repeat (3) @(negedge clk);
    bus.rx_ack = 1'b0;
    check("idle_ack_valid", bus.rx_valid, 1'b0);
    check("idle_ack_data", bus.rx_data, 8'h55);

    // 0xA3 with low stop bit, line low 3 bit times, then 0x3C
    r0 = n_rise; e0 = n_err;
    send_byte(8'hA3, 1'b0, 1'b0);
    check("ferr_pulse", n_err - e0, 1);
    check("ferr_no_valid", bus.rx_valid, 1'b0);
    drive_bit(1'b0, -1);
    drive_bit(1'b0, -1);
    drive_bit(1'b1, -1);
    send_byte(8'h3C, 1'b1, 1'b0);
    check("b3c_data", bus.rx_data, 8'h3C);
    check("b3c_valid", bus.rx_valid, 1'b1);
    check("b3c_ferr_total", n_err - e0, 1);
    check("b3c_rises", n_rise - r0, 1);
    ack_pulse();

    // 100-cycle glitch, then 0xFF
    r0 = n_rise; e0 = n_err; o0 = n_ovr;
    rx = 1'b0;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    repeat (BIT) @(negedge clk);
    check("glitch_rises", n_rise - r0, 0);
    check("glitch_ferr", n_err - e0, 0);
    check("glitch_ovr", n_ovr - o0, 0);
    send_byte(8'hFF, 1'b1, 1'b0);
    check("bff_data", bus.rx_data, 8'hFF);
    check("bff_valid", bus.rx_valid, 1'b1);
    ack_pulse();

    // 0x11, 0x22 back-to-back without ack -> overrun
    r0 = n_rise; o0 = n_ovr;
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h22, 1'b1, 1'b0);
    check("ovr_data", bus.rx_data, 8'h11);
    check("ovr_valid", bus.rx_valid, 1'b1);
    check("ovr_pulse", n_ovr - o0, 1);
    check("ovr_rises", n_rise - r0, 1);
    ack_pulse();

    // 0x11, 0x22 with ack on the second completion cycle
    r0 = n_rise; o0 = n_ovr;
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h22, 1'b1, 1'b1);
    check("ackdone_data", bus.rx_data, 8'h22);
    check("ackdone_valid", bus.rx_valid, 1'b1);
    check("ackdone_no_ovr", n_ovr - o0, 0);
    check("ackdone_rises", n_rise - r0, 1);
    ack_pulse();

    // reset during bit 4 of 0x5A, then 0xC3
    r0 = n_rise; e0 = n_err; o0 = n_ovr;
    pat = 8'h5A;
    drive_bit(1'b0, -1);
    for (int k = 0; k < 4; k++) drive_bit(pat[k], -1);
    rx = pat[4];
    repeat (100) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("mrst_data", bus.rx_data, 8'h00);
    check("mrst_valid", bus.rx_valid, 1'b0);
    check("mrst_rises", n_rise - r0, 0);
    check("mrst_ferr", n_err - e0, 0);
    check("mrst_ovr", n_ovr - o0, 0);
    send_byte(8'hC3, 1'b1, 1'b0);
    check("bc3_data", bus.rx_data, 8'hC3);
    check("bc3_valid", bus.rx_valid, 1'b1);
    check("bc3_clean", (n_err - e0) + (n_ovr - o0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BAUD_RATE, default 115200, serial bit rate in bit/s.
REQ-002 SHALL have parameter CLK_VAL_MHZ, default 50, clk frequency in MHz.
REQ-003 SHALL derive BAUD_DIV = CLK_VAL_MHZ*1000000/BAUD_RATE (integer division; 434 at defaults) and HALF_DIV = BAUD_DIV/2.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 rx  input  1  asynchronous serial line, idle high.
REQ-007 rx_ack  input  1  consumer accepts rx_data when high together with rx_valid.
REQ-008 rx_data  output  8  last received byte, stable while rx_valid high.
REQ-009 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-010 rx_frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 rx_overrun  output  1  one-cycle pulse: byte completed while rx_valid high and no rx_ack.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer (reset value 1) to form rx_s; all decisions use rx_s only.
REQ-013 SHALL use a 13-bit baud counter; BAUD_DIV is limited to 2..8191.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE; baud counter cleared on every state entry.
REQ-015 IDLE: rx_s==0 -> START.
REQ-016 START: when counter==HALF_DIV-1, rx_s==0 -> DATA; rx_s==1 -> IDLE (glitch rejected, no output activity).
REQ-017 DATA: when counter==BAUD_DIV-1, sample rx_s into shift register MSB with right shift (LSB-first framing), clear counter, increment 3-bit bit index; after the 8th sample -> STOP.
REQ-018 STOP: when counter==BAUD_DIV-1, rx_s==1 -> byte complete, IDLE; rx_s==0 -> rx_frame_err pulse, byte discarded, WAIT_IDLE.
REQ-019 WAIT_IDLE: stay until rx_s==1, then IDLE; no start detection meanwhile.
REQ-020 Byte complete with rx_valid==0, or rx_valid==1 and rx_ack==1 same cycle: rx_data <= shift register, rx_valid <= 1 next cycle, no overrun.
REQ-021 Byte complete with rx_valid==1 and rx_ack==0: rx_data and rx_valid unchanged, new byte discarded, rx_overrun pulses one cycle.
REQ-022 rx_valid==1 and rx_ack==1 with no byte completing: rx_valid <= 0 next cycle; rx_data retains value.
REQ-023 rx_ack while rx_valid==0 SHALL be ignored.
REQ-024 Latency: rx_valid rises 1 cycle after the stop-bit sample cycle; sampling points are mid-bit relative to the synchronized falling edge of start.

Reset
REQ-025 While rst==0 at a clk edge: state IDLE, counters 0, shift register 0, synchronizer 1s, rx_data 8'h00, rx_valid 0, rx_frame_err 0, rx_overrun 0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no rx_valid, rx_frame_err or rx_overrun; after release, next start bit detected normally.

Verification
REQ-027 Send 0x55 at 115200 baud, defaults -> rx_valid=1, rx_data=8'h55 within 1 bit time after stop start; rx_ack pulse -> rx_valid=0 next cycle.
REQ-028 Send 0xA3 with stop bit low -> rx_frame_err one pulse, rx_valid stays 0; line held low 3 bit times then high -> next 0x3C received correctly.
REQ-029 Low glitch of 100 clk cycles on idle line -> returns to IDLE, no outputs; following 0xFF received as 8'hFF.
REQ-030 Send 0x11 then 0x22 back-to-back, no rx_ack -> rx_data=8'h11 retained, rx_overrun one pulse at second stop sample.
REQ-031 Send 0x11, 0x22 with rx_ack asserted exactly on second byte's completion cycle -> rx_valid stays 1, rx_data=8'h22, no overrun.
REQ-032 rst low during bit 4 of 0x5A for 2 cycles -> all outputs reset values, no pulses; subsequent 0xC3 received as 8'hC3.
